vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 4, clk cycles per pixel (>=1)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- SCALE_SHIFT, 1, log2 address downscale
- CW, 10, counter width
- AW, 17, pix_addr width

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, system clock
- rst, in, 1, reset (synchronous, active-high)
- hmir, in, 1, horizontal mirror request
- vmir, in, 1, vertical mirror request
- pix_ce, out, 1, pixel-advance strobe
- h_cnt, out, CW, horizontal position
- v_cnt, out, CW, vertical position
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- valid, out, 1, active-region flag
- pix_addr, out, AW, frame-buffer address
- line_start, out, 1, one-clk pulse at line begin
- frame_start, out, 1, one-clk pulse at frame begin

REQ-003 SHALL have exactly one clock, clk; all state SHALL update on its rising edge.
REQ-004 SHALL use a synchronous, active-high reset, rst.

Function
REQ-005 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; defaults give 800 and 525.
REQ-006 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping to 0; pix_ce=1 exactly when the prescaler equals CLK_DIV-1.
REQ-007 With CLK_DIV=1, pix_ce SHALL be held constant 1.
REQ-008 h_cnt SHALL increment only on clocks where pix_ce=1.
REQ-009 When h_cnt=H_TOTAL-1 with pix_ce=1, h_cnt SHALL wrap to 0 and v_cnt SHALL increment.
REQ-010 When v_cnt=V_TOTAL-1 during that wrap, v_cnt SHALL wrap to 0.
REQ-011 hsync SHALL equal SYNC_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~SYNC_POL otherwise.
REQ-012 vsync SHALL follow the same rule on v_cnt with the V_* parameters.
REQ-013 valid SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-014 hsync, vsync and valid SHALL be zero-latency decodes of the registered counters.
REQ-015 SHALL hold internal mirror flags hm_q and vm_q, loaded from hmir and vmir only on the edge where the counters wrap to (0,0); mid-frame changes SHALL have no effect until the next frame.
REQ-016 SHALL form mirrored coordinates:
- mx = hm_q ? H_ACTIVE-1-h_cnt : h_cnt
- my = vm_q ? V_ACTIVE-1-v_cnt : v_cnt
REQ-017 pix_addr SHALL be (my>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (mx>>SCALE_SHIFT) when valid=1, and 0 when valid=0.
REQ-018 pix_addr SHALL be truncated to AW bits.
REQ-019 line_start SHALL be a registered pulse, high for exactly one clk, in the first cycle h_cnt holds 0 after a wrap.
REQ-020 frame_start SHALL be a registered pulse, high for exactly one clk, in the first cycle the counters hold (0,0) after a wrap; when it fires, line_start SHALL fire in the same clk.
REQ-021 Neither line_start nor frame_start SHALL pulse on reset release.

Reset
REQ-022 While rst=1 the following SHALL hold:
- prescaler, h_cnt, v_cnt = 0
- hm_q, vm_q = 0
- line_start, frame_start, pix_ce = 0
- hsync, vsync = ~SYNC_POL
- valid = 1 (decode of (0,0)); pix_addr = 0
REQ-023 Asserting rst mid-frame SHALL restart the timing on the next edge with no partial sync pulse retained.
REQ-024 After rst deasserts, the first pix_ce SHALL occur CLK_DIV clks later, taking h_cnt to 1.

Verification
REQ-025 Defaults, release rst: pix_ce on clks 4, 8, 12...; h_cnt=1 after clk 4; no frame_start pulse.
REQ-026 Sweep one frame: hsync=0 exactly for h_cnt 656..751; vsync=0 exactly for v_cnt 490..491; valid=0 at h_cnt=640 and at v_cnt=480.
REQ-027 Counters at (799,524), then pix_ce: counters go to (0,0); frame_start and line_start each high for one clk; no pulse on other clks.
REQ-028 hmir=1 asserted at v_cnt=100: pix_addr unchanged for the rest of the frame; at the next (0,0), pix_addr=319.
REQ-029 No mirror: (h,v)=(5,3) gives pix_addr=322; (h,v)=(641,3) gives pix_addr=0 with valid=0.
REQ-030 rst pulsed at (h,v)=(700,491): after release hsync=1, vsync=1, counters=(0,0); the next line's hsync pulse occurs at h_cnt=656.

Source files
------------

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA-style raster timing generator.
// A prescaler sets the pixel rate. Horizontal and vertical counters walk the
// full raster. Sync, valid and frame-buffer address are decoded combinationally
// from those counters. Mirror requests are latched once per frame, so a frame
// always uses one mirror setting from start to end.
module vga_scan_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 4,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int CW          = 10,
  parameter int AW          = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hmir,
  input  logic          vmir,
  output logic          pix_ce,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          hsync,
  output logic          vsync,
  output logic          valid,
  output logic [AW-1:0] pix_addr,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_ACT_M1   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_M1   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]   LINE_WORDS = 32'(H_ACTIVE >> SCALE_SHIFT);

  logic          pix_ce_s;
  logic [CW-1:0] h_cnt_r;
  logic [CW-1:0] v_cnt_r;
  logic          hm_q;
  logic          vm_q;
  logic          line_start_r;
  logic          frame_start_r;
  logic          h_wrap_s;
  logic          f_wrap_s;
  logic          valid_s;
  logic          hsync_s;
  logic          vsync_s;
  logic [CW-1:0] mx_s;
  logic [CW-1:0] my_s;
  logic [31:0]   addr_full_s;
  logic [AW-1:0] pix_addr_s;

  // Half-open window test lo <= c < hi, shared by both sync decodes.
  function automatic logic in_window(input logic [CW-1:0] c,
                                     input logic [CW-1:0] lo,
                                     input logic [CW-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

  if (CLK_DIV > 1) begin : g_presc
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    logic [PW-1:0] presc_r;

    // Pixel-rate prescaler: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
      if (rst) begin
        presc_r <= '0;
      end else if (presc_r == PRESC_LAST) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end

    assign pix_ce_s = (presc_r == PRESC_LAST);
  end else begin : g_nopresc
    // One pixel per clock: the strobe is permanently high.
    assign pix_ce_s = 1'b1;
  end

  assign h_wrap_s = pix_ce_s && (h_cnt_r == H_LAST);
  assign f_wrap_s = h_wrap_s && (v_cnt_r == V_LAST);

  // Raster counters: advance on the pixel strobe, with the line wrap stepping the row.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (pix_ce_s) begin
      if (h_cnt_r == H_LAST) begin
        h_cnt_r <= '0;
        if (v_cnt_r == V_LAST) begin
          v_cnt_r <= '0;
        end else begin
          v_cnt_r <= v_cnt_r + CW'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + CW'(1);
      end
    end
  end

  // Line/frame start pulses and per-frame mirror latch, all keyed to the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      hm_q          <= 1'b0;
      vm_q          <= 1'b0;
    end else begin
      line_start_r  <= h_wrap_s;
      frame_start_r <= f_wrap_s;
      if (f_wrap_s) begin
        hm_q <= hmir;
        vm_q <= vmir;
      end
    end
  end

  // Zero-latency decode of sync, active region and mirrored frame-buffer address.
  always_comb begin
    hsync_s     = in_window(h_cnt_r, H_SYNC_BEG, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vsync_s     = in_window(v_cnt_r, V_SYNC_BEG, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    valid_s     = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    mx_s        = hm_q ? (H_ACT_M1 - h_cnt_r) : h_cnt_r;
    my_s        = vm_q ? (V_ACT_M1 - v_cnt_r) : v_cnt_r;
    addr_full_s = 32'(my_s >> SCALE_SHIFT) * LINE_WORDS + 32'(mx_s >> SCALE_SHIFT);
    if (valid_s) begin
      pix_addr_s = AW'(addr_full_s);
    end else begin
      pix_addr_s = '0;
    end
  end

  assign pix_ce      = pix_ce_s;
  assign h_cnt       = h_cnt_r;
  assign v_cnt       = v_cnt_r;
  assign hsync       = hsync_s;
  assign vsync       = vsync_s;
  assign valid       = valid_s;
  assign pix_addr    = pix_addr_s;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed bench for vga_scan_gen.
// Instance a uses the default 640x480 timing with a divide-by-4 pixel rate.
// Instance b uses a tiny raster with one pixel per clock and active-high sync,
// so whole frames, frame wraps, mirroring and mid-frame reset can be swept.
module tb_vga_scan_gen;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        hmir_a, vmir_a, hmir_b, vmir_b;

  logic        a_pix_ce, a_hsync, a_vsync, a_valid, a_ls, a_fs;
  logic [9:0]  a_h, a_v;
  logic [16:0] a_addr;
  logic        b_pix_ce, b_hsync, b_vsync, b_valid, b_ls, b_fs;
  logic [9:0]  b_h, b_v;
  logic [16:0] b_addr;

  int checks   = 0;
  int failures = 0;
  int na       = 0;
  int nb       = 0;
  int eh       = 0;
  int ev       = 0;

  always #5 clk = ~clk;

  vga_scan_gen dut_a (
    .clk(clk), .rst(rst_a), .hmir(hmir_a), .vmir(vmir_a),
    .pix_ce(a_pix_ce), .h_cnt(a_h), .v_cnt(a_v), .hsync(a_hsync), .vsync(a_vsync),
    .valid(a_valid), .pix_addr(a_addr), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_scan_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(1), .SYNC_POL(1'b1), .SCALE_SHIFT(1), .CW(10), .AW(17)
  ) dut_b (
    .clk(clk), .rst(rst_b), .hmir(hmir_b), .vmir(vmir_b),
    .pix_ce(b_pix_ce), .h_cnt(b_h), .v_cnt(b_v), .hsync(b_hsync), .vsync(b_vsync),
    .valid(b_valid), .pix_addr(b_addr), .line_start(b_ls), .frame_start(b_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance instance a to clk count c after its reset release.
  task automatic goto_a(input int c);
    while (na < c) begin
      tick();
      na++;
    end
  endtask

  initial begin
    int h, v, mx, my, exp_addr;
    logic exp_valid;

    rst_a = 1'b1; rst_b = 1'b1;
    hmir_a = 1'b0; vmir_a = 1'b0; hmir_b = 1'b0; vmir_b = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("a_rst_pix_ce", 32'(a_pix_ce), 32'd0);
    chk("a_rst_h", 32'(a_h), 32'd0);
    chk("a_rst_v", 32'(a_v), 32'd0);
    chk("a_rst_hsync", 32'(a_hsync), 32'd1);
    chk("a_rst_vsync", 32'(a_vsync), 32'd1);
    chk("a_rst_valid", 32'(a_valid), 32'd1);
    chk("a_rst_addr", 32'(a_addr), 32'd0);
    chk("a_rst_ls", 32'(a_ls), 32'd0);
    chk("a_rst_fs", 32'(a_fs), 32'd0);
    chk("b_rst_pix_ce", 32'(b_pix_ce), 32'd1);
    chk("b_rst_hsync", 32'(b_hsync), 32'd0);
    chk("b_rst_vsync", 32'(b_vsync), 32'd0);

    // Release: pix_ce on the 4th, 8th, 12th clk; h steps on those edges; no pulses
    rst_a = 1'b0; rst_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      na++;
      chk("a_rel_pix_ce", 32'(a_pix_ce), 32'((k % 4) == 3));
      chk("a_rel_h", 32'(a_h), 32'(k / 4));
      chk("a_rel_ls", 32'(a_ls), 32'd0);
      chk("a_rel_fs", 32'(a_fs), 32'd0);
    end

    // Address and active region on line 3
    goto_a(4 * (3 * 800 + 5));
    chk("a_h5", 32'(a_h), 32'd5);
    chk("a_v3", 32'(a_v), 32'd3);
    chk("a_valid_5_3", 32'(a_valid), 32'd1);
    chk("a_addr_5_3", 32'(a_addr), 32'd322);
    goto_a(4 * (3 * 800 + 639));
    chk("a_valid_639", 32'(a_valid), 32'd1);
    chk("a_addr_639_3", 32'(a_addr), 32'd639);
    goto_a(4 * (3 * 800 + 640));
    chk("a_valid_640", 32'(a_valid), 32'd0);
    chk("a_addr_640", 32'(a_addr), 32'd0);
    goto_a(4 * (3 * 800 + 641));
    chk("a_h641", 32'(a_h), 32'd641);
    chk("a_valid_641", 32'(a_valid), 32'd0);
    chk("a_addr_641", 32'(a_addr), 32'd0);

    // Horizontal sync window edges 656..751 (active-low)
    goto_a(4 * (3 * 800 + 655));
    chk("a_hsync_655", 32'(a_hsync), 32'd1);
    goto_a(4 * (3 * 800 + 656));
    chk("a_hsync_656", 32'(a_hsync), 32'd0);
    chk("a_vsync_line3", 32'(a_vsync), 32'd1);
    goto_a(4 * (3 * 800 + 751) + 3);
    chk("a_hsync_751", 32'(a_hsync), 32'd0);
    goto_a(4 * (3 * 800 + 752));
    chk("a_hsync_752", 32'(a_hsync), 32'd1);

    // Line start pulse: one clk only, although h holds 0 for four clks
    goto_a(4 * 3200 - 1);
    chk("a_h799", 32'(a_h), 32'd799);
    chk("a_ls_before", 32'(a_ls), 32'd0);
    goto_a(4 * 3200);
    chk("a_h_wrap", 32'(a_h), 32'd0);
    chk("a_v4", 32'(a_v), 32'd4);
    chk("a_ls_pulse", 32'(a_ls), 32'd1);
    chk("a_fs_none", 32'(a_fs), 32'd0);
    goto_a(4 * 3200 + 1);
    chk("a_ls_drop", 32'(a_ls), 32'd0);
    chk("a_h_hold0", 32'(a_h), 32'd0);

    // Instance b: restart, then sweep ~2.8 frames with mirror changes
    rst_b = 1'b1;
    tick();
    chk("b_rst_h", 32'(b_h), 32'd0);
    chk("b_rst_v", 32'(b_v), 32'd0);
    chk("b_rst_ls", 32'(b_ls), 32'd0);
    rst_b = 1'b0;
    nb = 0;
    while (nb < 1718) begin
      if (nb == 608 + 5 * 32 + 3) begin
        hmir_b = 1'b1; vmir_b = 1'b1;
      end
      if (nb == 1440) begin
        hmir_b = 1'b0; vmir_b = 1'b0;
      end
      if (((nb + 1) % 608) == 0) begin
        eh = int'(hmir_b); ev = int'(vmir_b);
      end
      tick();
      nb++;
      h = nb % 32;
      v = (nb / 32) % 19;
      mx = (eh != 0) ? 15 - h : h;
      my = (ev != 0) ? 11 - v : v;
      exp_valid = (h < 16) && (v < 12);
      exp_addr = exp_valid ? (my / 2) * 8 + (mx / 2) : 0;
      chk("b_h", 32'(b_h), 32'(h));
      chk("b_v", 32'(b_v), 32'(v));
      chk("b_pix_ce", 32'(b_pix_ce), 32'd1);
      chk("b_hsync", 32'(b_hsync), 32'((h >= 20) && (h < 26)));
      chk("b_vsync", 32'(b_vsync), 32'((v >= 14) && (v < 16)));
      chk("b_valid", 32'(b_valid), 32'(exp_valid));
      chk("b_addr", 32'(b_addr), 32'(exp_addr));
      chk("b_ls", 32'(b_ls), 32'(h == 0));
      chk("b_fs", 32'(b_fs), 32'((h == 0) && (v == 0)));
    end

    // Mid-frame reset inside both sync pulses, while mirroring is active
    chk("b_pre_hsync", 32'(b_hsync), 32'd1);
    chk("b_pre_vsync", 32'(b_vsync), 32'd1);
    rst_b = 1'b1;
    tick();
    chk("b_mrst_h", 32'(b_h), 32'd0);
    chk("b_mrst_v", 32'(b_v), 32'd0);
    chk("b_mrst_hsync", 32'(b_hsync), 32'd0);
    chk("b_mrst_vsync", 32'(b_vsync), 32'd0);
    chk("b_mrst_valid", 32'(b_valid), 32'd1);
    chk("b_mrst_addr", 32'(b_addr), 32'd0);
    chk("b_mrst_ls", 32'(b_ls), 32'd0);
    chk("b_mrst_fs", 32'(b_fs), 32'd0);
    rst_b = 1'b0;
    tick();
    chk("b_post_h", 32'(b_h), 32'd1);
    chk("b_post_addr_unmirrored", 32'(b_addr), 32'd0);
    chk("b_post_ls", 32'(b_ls), 32'd0);
    chk("b_post_fs", 32'(b_fs), 32'd0);
    repeat (18) tick();
    chk("b_post_h19", 32'(b_h), 32'd19);
    chk("b_post_hsync19", 32'(b_hsync), 32'd0);
    tick();
    chk("b_post_hsync20", 32'(b_hsync), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
